// File: rtl/ldtu_ofifo_ctrl_pkg.sv
// Shared constants for the LiTe-DTU output-FIFO read controller: state encodings,
// trailer/idle word constants, error flag indices and the trailer builder.
package ldtu_ofifo_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_TRAIL = 2'd3;

  localparam logic [3:0]  TRAILER_HDR = 4'hD;
  localparam logic [31:0] IDLE_WORD   = 32'hEAAA_EAAA;

  localparam int unsigned ERR_TIMEOUT  = 0;
  localparam int unsigned ERR_SPURIOUS = 1;

  // frameNum is the count of frames completed before this trailer goes out
  function automatic logic [31:0] build_trailer(input logic [7:0] frameNum,
                                                input logic [7:0] frameLen);
    return {TRAILER_HDR, 12'h000, frameNum, frameLen};
  endfunction

endpackage

// File: rtl/ldtu_frame_counter.sv
// Word-in-frame and completed-frame counters for the output FIFO read controller;
// also assembles the trailer word for the frame currently being closed.
module ldtu_frame_counter
  import ldtu_ofifo_ctrl_pkg::*;
#(
  parameter int unsigned FrameLen = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wordAccept_i,
  input  logic        trailAccept_i,
  output logic        lastWord_o,
  output logic [7:0]  frameCnt_o,
  output logic [31:0] trailer_o
);

  localparam logic [7:0] LastIdx      = 8'(FrameLen - 1);
  localparam logic [7:0] FrameLenByte = 8'(FrameLen);

  logic [7:0] wordCnt_q, wordCnt_d;
  logic [7:0] frameCnt_q, frameCnt_d;

  assign lastWord_o = (wordCnt_q == LastIdx);
  assign frameCnt_o = frameCnt_q;
  assign trailer_o  = build_trailer(frameCnt_q, FrameLenByte);

  // frameCnt wraps 255 -> 0 naturally through the 8-bit add
  always_comb begin
    wordCnt_d  = wordCnt_q;
    frameCnt_d = frameCnt_q;
    if (wordAccept_i) begin
      wordCnt_d = lastWord_o ? 8'd0 : wordCnt_q + 8'd1;
    end
    if (trailAccept_i) begin
      frameCnt_d = frameCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wordCnt_q  <= 8'd0;
      frameCnt_q <= 8'd0;
    end else begin
      wordCnt_q  <= wordCnt_d;
      frameCnt_q <= frameCnt_d;
    end
  end

endmodule

// File: rtl/ldtu_ofifo_read_ctrl.sv
// Read-side controller of the Hamming-protected output FIFO: one read at a time,
// decoded word handed to the serializer, trailer after every FrameLen words.
// Optional idle-word fill on the output is enabled by LDTU_OFIFO_IDLE_FILL_EN.
module ldtu_ofifo_read_ctrl
  import ldtu_ofifo_ctrl_pkg::*;
#(
  parameter int unsigned FrameLen   = 8,
  parameter int unsigned DecTimeout = 4,
  parameter int unsigned Nbits_dec  = 32
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  input  logic                 dec_valid,
  input  logic [Nbits_dec-1:0] dec_data,
  output logic [Nbits_dec-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_is_trailer,
  output logic [7:0]           frame_cnt,
  output logic [1:0]           err_flags
);

  localparam logic [3:0] TimeoutCnt = 4'(DecTimeout);

  logic [1:0]           state_q, state_d;
  logic                 fifoRead_q, fifoRead_d;
  logic [3:0]           waitCnt_q, waitCnt_d;
  logic [Nbits_dec-1:0] outData_q, outData_d;
  logic                 outValid_q, outValid_d;
  logic                 outTrailer_q, outTrailer_d;
  logic [1:0]           errFlags_q, errFlags_d;

  logic        wordAccept;
  logic        trailAccept;
  logic        lastWord;
  logic [31:0] trailer;

  ldtu_frame_counter #(
    .FrameLen (FrameLen)
  ) u_frame_counter (
    .clk_i         (CLK),
    .reset_i       (reset),
    .wordAccept_i  (wordAccept),
    .trailAccept_i (trailAccept),
    .lastWord_o    (lastWord),
    .frameCnt_o    (frame_cnt),
    .trailer_o     (trailer)
  );

  always_comb begin
    state_d      = state_q;
    fifoRead_d   = 1'b0;
    waitCnt_d    = waitCnt_q;
    outData_d    = outData_q;
    outValid_d   = outValid_q;
    outTrailer_d = outTrailer_q;
    errFlags_d   = errFlags_q;
    wordAccept   = 1'b0;
    trailAccept  = 1'b0;

    // A decoder strobe is only expected while a read is outstanding
    if (dec_valid && (state_q != ST_WAIT)) begin
      errFlags_d[ERR_SPURIOUS] = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          fifoRead_d = 1'b1;
          waitCnt_d  = 4'd0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dec_valid) begin
          outData_d    = dec_data;
          outValid_d   = 1'b1;
          outTrailer_d = 1'b0;
          state_d      = ST_HOLD;
        end else begin
          waitCnt_d = waitCnt_q + 4'd1;
          if (waitCnt_d == TimeoutCnt) begin
            errFlags_d[ERR_TIMEOUT] = 1'b1;
            state_d                 = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          wordAccept = 1'b1;
          if (lastWord) begin
            outData_d    = trailer;
            outTrailer_d = 1'b1;
            state_d      = ST_TRAIL;
          end else begin
            outValid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_TRAIL: begin
        if (out_ready) begin
          trailAccept  = 1'b1;
          outValid_d   = 1'b0;
          outTrailer_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef LDTU_OFIFO_IDLE_FILL_EN
    // Keep the serializer fed with filler whenever no real word is held
    if ((state_d == ST_IDLE) || (state_d == ST_WAIT)) begin
      outData_d    = IDLE_WORD;
      outValid_d   = 1'b1;
      outTrailer_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fifoRead_q   <= 1'b0;
      waitCnt_q    <= 4'd0;
      outData_q    <= '0;
      outValid_q   <= 1'b0;
      outTrailer_q <= 1'b0;
      errFlags_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      fifoRead_q   <= fifoRead_d;
      waitCnt_q    <= waitCnt_d;
      outData_q    <= outData_d;
      outValid_q   <= outValid_d;
      outTrailer_q <= outTrailer_d;
      errFlags_q   <= errFlags_d;
    end
  end

  assign fifo_read      = fifoRead_q;
  assign out_data       = outData_q;
  assign out_valid      = outValid_q;
  assign out_is_trailer = outTrailer_q;
  assign err_flags      = errFlags_q;

endmodule

// File: tb/tb_ldtu_ofifo_read_ctrl.sv
// Directed bench for ldtu_ofifo_read_ctrl with FrameLen=2, DecTimeout=4.
// Idle-fill expectations follow LDTU_OFIFO_IDLE_FILL_EN when it is defined.
module tb_ldtu_ofifo_read_ctrl;

`ifdef LDTU_OFIFO_IDLE_FILL_EN
  localparam logic IdleFill = 1'b1;
`else
  localparam logic IdleFill = 1'b0;
`endif

  logic        CLK;
  logic        reset;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_read;
  logic        dec_valid;
  logic [31:0] dec_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_is_trailer;
  logic [7:0]  frame_cnt;
  logic [1:0]  err_flags;

  int checks = 0;
  int errors = 0;

  ldtu_ofifo_read_ctrl #(
    .FrameLen   (2),
    .DecTimeout (4),
    .Nbits_dec  (32)
  ) dut (
    .CLK            (CLK),
    .reset          (reset),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_read      (fifo_read),
    .dec_valid      (dec_valid),
    .dec_data       (dec_data),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_is_trailer (out_is_trailer),
    .frame_cnt      (frame_cnt),
    .err_flags      (err_flags)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Wait (bounded) for a read pulse, then return the decoded word after lat cycles
  task automatic applyStimulus(input logic [31:0] word, input int lat);
    int n;
    n = 0;
    while ((fifo_read !== 1'b1) && (n < 10)) begin
      tick();
      n++;
    end
    checkOutput("fifo_read_issued", 32'(fifo_read), 32'd1);
    repeat (lat) tick();
    dec_valid = 1'b1;
    dec_data  = word;
    tick();
    dec_valid = 1'b0;
    dec_data  = 32'd0;
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    fifo_empty = 1'b1;
    dec_valid  = 1'b0;
    dec_data   = 32'd0;
    out_ready  = 1'b0;
    tick();
    tick();
    checkOutput("rst_fifo_read", 32'(fifo_read), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_trailer_flag", 32'(out_is_trailer), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_err_flags", 32'(err_flags), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] basic frame stream");
    enable     = 1'b1;
    fifo_empty = 1'b0;
    out_ready  = 1'b1;
    applyStimulus(32'h11, 1);
    checkOutput("w11_valid", 32'(out_valid), 32'd1);
    checkOutput("w11_data", out_data, 32'h11);
    checkOutput("w11_not_trailer", 32'(out_is_trailer), 32'd0);
    tick();
    checkOutput("w11_released", 32'(out_valid), 32'(IdleFill));
    applyStimulus(32'h22, 1);
    checkOutput("w22_data", out_data, 32'h22);
    tick();
    checkOutput("trl0_data", out_data, 32'hD000_0002);
    checkOutput("trl0_flag", 32'(out_is_trailer), 32'd1);
    checkOutput("trl0_valid", 32'(out_valid), 32'd1);
    tick();
    checkOutput("trl0_frame_cnt", 32'(frame_cnt), 32'd1);
    checkOutput("trl0_flag_clr", 32'(out_is_trailer), 32'd0);
    applyStimulus(32'h33, 1);
    checkOutput("w33_data", out_data, 32'h33);
    tick();

    $display("[TB] serializer stall");
    out_ready = 1'b0;
    applyStimulus(32'hABCD_0001, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_data", out_data, 32'hABCD_0001);
      checkOutput("stall_no_read", 32'(fifo_read), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    checkOutput("trl1_data", out_data, 32'hD000_0102);
    checkOutput("trl1_flag", 32'(out_is_trailer), 32'd1);
    tick();
    checkOutput("trl1_frame_cnt", 32'(frame_cnt), 32'd2);

    $display("[TB] decoder timeout");
    tick();
    checkOutput("to_read_pulse", 32'(fifo_read), 32'd1);
    checkOutput("to_err_before", 32'(err_flags), 32'd0);
    tick();
    tick();
    tick();
    checkOutput("to_err_cycle3", 32'(err_flags), 32'd0);
    tick();
    checkOutput("to_err_set", 32'(err_flags), 32'd1);
    checkOutput("to_no_read", 32'(fifo_read), 32'd0);
    tick();
    checkOutput("to_reread", 32'(fifo_read), 32'd1);
    enable    = 1'b0;
    dec_valid = 1'b1;
    dec_data  = 32'h44;
    tick();
    dec_valid = 1'b0;
    checkOutput("w44_data", out_data, 32'h44);
    checkOutput("w44_valid", 32'(out_valid), 32'd1);
    tick();

    $display("[TB] spurious decoder strobe");
    dec_valid = 1'b1;
    dec_data  = 32'h5555;
    tick();
    dec_valid = 1'b0;
    checkOutput("spur_err", 32'(err_flags), 32'd3);
    checkOutput("spur_out_valid", 32'(out_valid), 32'(IdleFill));
    checkOutput("spur_no_read", 32'(fifo_read), 32'd0);
    enable = 1'b1;
    applyStimulus(32'h66, 0);
    checkOutput("w66_data", out_data, 32'h66);
    tick();
    checkOutput("trl2_data", out_data, 32'hD000_0202);
    checkOutput("trl2_flag", 32'(out_is_trailer), 32'd1);
    tick();
    checkOutput("trl2_frame_cnt", 32'(frame_cnt), 32'd3);
    checkOutput("err_sticky", 32'(err_flags), 32'd3);

    $display("[TB] reset while holding a word");
    applyStimulus(32'h77, 0);
    tick();
    out_ready = 1'b0;
    applyStimulus(32'h88, 0);
    checkOutput("w88_held", out_data, 32'h88);
    reset = 1'b1;
    tick();
    checkOutput("mrst_fifo_read", 32'(fifo_read), 32'd0);
    checkOutput("mrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mrst_trailer_flag", 32'(out_is_trailer), 32'd0);
    checkOutput("mrst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("mrst_err_flags", 32'(err_flags), 32'd0);
    checkOutput("mrst_out_data", out_data, 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(32'h99, 0);
    checkOutput("w99_data", out_data, 32'h99);
    tick();
    checkOutput("w99_not_trailer", 32'(out_is_trailer), 32'd0);
    applyStimulus(32'hAA, 0);
    tick();
    checkOutput("post_rst_trailer", out_data, 32'hD000_0002);
    tick();
    checkOutput("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("[TB] frame counter wrap");
    for (int f = 1; f < 256; f++) begin
      applyStimulus(32'(f), 0);
      tick();
      applyStimulus(32'(f) | 32'h100, 0);
      tick();
      checkOutput("wrap_trailer", out_data, {4'hD, 12'h000, 8'(f), 8'h02});
      tick();
    end
    checkOutput("frame_cnt_wrapped", 32'(frame_cnt), 32'd0);

    $display("[TB] empty FIFO");
    fifo_empty = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("empty_no_read", 32'(fifo_read), 32'd0);
    end
`ifdef LDTU_OFIFO_IDLE_FILL_EN
    checkOutput("idle_fill_data", out_data, 32'hEAAA_EAAA);
    checkOutput("idle_fill_valid", 32'(out_valid), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldtu_ofifo_read_ctrl.md
Name: ldtu_ofifo_read_ctrl

Overview:
Read-side controller for the 16-deep Hamming-protected output FIFO. It issues single-word read pulses to the FIFO and waits for the decoded 32-bit word from the Hamming decoder. It then presents that word to the serializer over a valid/ready handshake. After every FrameLen data words it inserts a frame trailer word. Sits between the FIFO/decoder pair and the output serializer.

Parameters:
FrameLen, 8, data words per frame before a trailer is inserted (1..255)
DecTimeout, 4, max cycles waited in WAIT for dec_valid before aborting (1..15)
Nbits_dec, 32, decoded data word width (fixed at 32; trailer format depends on it)

Ports:
CLK  input  1  LiTe-DTU clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  1: start new FIFO reads; 0: finish in-flight word/trailer, then stay IDLE
fifo_empty  input  1  empty flag of the output FIFO
fifo_read  output  1  registered one-cycle read pulse to FIFO
dec_valid  input  1  decoder output strobe (one cycle)
dec_data  input  32  decoded data word, valid with dec_valid
out_data  output  32  word to serializer
out_valid  output  1  out_data valid
out_ready  input  1  serializer accepts out_data this cycle
out_is_trailer  output  1  1 when out_data is a trailer word
frame_cnt  output  8  completed-frame counter
err_flags  output  2  sticky: [0] decode timeout, [1] spurious dec_valid

Behaviour:
- Reset: synchronous, active-high. Outputs all zero: fifo_read, out_valid, out_is_trailer, frame_cnt, err_flags. out_data=0. word_cnt=0, state=IDLE. Reset asserted mid-operation has the same effect; a held word is discarded and not re-read.
- States: IDLE, WAIT, HOLD, TRAIL.
- IDLE: if enable && !fifo_empty, then fifo_read<=1 for exactly one cycle, wait counter<=0, go WAIT. Otherwise no read.
- WAIT: fifo_read=0. On dec_valid, out_data<=dec_data, out_valid<=1, go HOLD. Otherwise increment the wait counter. If the counter reaches DecTimeout without dec_valid, set err_flags[0] and go IDLE; no word is counted.
- HOLD: out_valid=1, out_data is stable until accepted. On out_ready:
  - if word_cnt==FrameLen-1, then word_cnt<=0 and go TRAIL, with out_data<=trailer, out_valid=1, out_is_trailer=1;
  - otherwise word_cnt++, out_valid<=0, go IDLE.
- TRAIL: on out_ready, frame_cnt++ (wraps 255->0), out_valid<=0, out_is_trailer<=0, go IDLE.
- Trailer word: {4'hD, 12'h000, frame_cnt[7:0] (value before increment), FrameLen[7:0]}.
- Throughput: at most one data word per 3 cycles. Minimum path is IDLE -> WAIT (dec_valid in the next cycle) -> HOLD accepted.
- dec_valid in any state other than WAIT sets err_flags[1] and is otherwise ignored; held data is not overwritten.
- Only one read is outstanding at any time. fifo_read is never asserted when fifo_empty was 1 in the issuing cycle.
- enable drop: does not abort WAIT, HOLD or TRAIL. The block only blocks the next IDLE->WAIT transition. word_cnt is retained across enable toggles.
- err_flags clear only on reset.

Optional Feature:
LDTU_OFIFO_IDLE_FILL_EN
- Defined: in IDLE (and in WAIT) the block drives out_valid=1 with out_data=32'hEAAA_EAAA and out_is_trailer=0. Idle words are not counted. out_ready on an idle word has no effect. On capture, the data word replaces the idle word in the next cycle.
- Not defined: out_valid=0 in IDLE and WAIT.

Decomposition:
- Package ldtu_ofifo_ctrl_pkg holds:
  - the state enum (IDLE, WAIT, HOLD, TRAIL);
  - TRAILER_HDR=4'hD and IDLE_WORD=32'hEAAA_EAAA;
  - the err_flags bit indices.
- One sub-module, ldtu_frame_counter, holds word_cnt and frame_cnt with the wrap logic and trailer build. The FSM stays in the top module.

Test Plan:
- FrameLen=2, three FIFO words 0x11,0x22,0x33, decoder latency 1, out_ready=1 -> out stream 0x11, 0x22, trailer 0xD000_0002, then 0x33; frame_cnt=1.
- out_ready held 0 for 5 cycles in HOLD with 0xABCD_0001 -> out_data stable and out_valid=1 for the whole stall; no second fifo_read pulse.
- fifo_empty=0 with no dec_valid, DecTimeout=4 -> err_flags=2'b01 set 4 cycles after entering WAIT, state returns to IDLE, and the next fifo_read is issued.
- dec_valid pulse while in IDLE -> err_flags[1]=1, out_valid stays 0, no word counted.
- Reset asserted in HOLD with a pending word -> the next cycle shows all outputs 0 and state IDLE; after release, the first accepted word starts the frame at word_cnt=0.
- 256 trailers with FrameLen=1 -> frame_cnt wraps to 0; trailer field for the 256th trailer = 0xFF. With LDTU_OFIFO_IDLE_FILL_EN, fifo_empty=1 gives out_data=0xEAAA_EAAA with out_valid=1.
